// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the floppy-to-HPS sector request arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_XFER
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_NOMOUNT = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_WPROT   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_EJECT   = 3'd5;

    // Bytes-to-sectors shift for 512-byte sectors.
    localparam int SECT_SHIFT = 9;

endpackage

// File: rtl/sd_drive_table.sv
// Per-drive mount state (mounted, read-only, sector count) loaded from img_mounted pulses.
// Latency: fields update the cycle after the pulse; read port is combinational.
// Backpressure: none, every mount pulse is absorbed.
module sd_drive_table
    import sd_arb_pkg::*;
#(
    parameter int NUM_DRIVES = 2,
    parameter int LBA_W      = 32,
    parameter int DRV_W      = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [NUM_DRIVES-1:0] img_mounted,
    input  logic                  img_readonly,
    input  logic [63:0]           img_size,
    input  logic [DRV_W-1:0]      rd_drv,
    output logic [NUM_DRIVES-1:0] mounted,
    output logic                  rd_mounted,
    output logic                  rd_ro,
    output logic [LBA_W-1:0]      rd_sectors
);

    logic [NUM_DRIVES-1:0]            mounted_q, mounted_d;
    logic [NUM_DRIVES-1:0]            ro_q, ro_d;
    logic [NUM_DRIVES-1:0][LBA_W-1:0] sectors_q, sectors_d;

    always_comb begin
        mounted_d = mounted_q;
        ro_d      = ro_q;
        sectors_d = sectors_q;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (img_mounted[i]) begin
                mounted_d[i] = |img_size;
                ro_d[i]      = img_readonly;
                sectors_d[i] = img_size[LBA_W+SECT_SHIFT-1:SECT_SHIFT];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mounted_q <= '0;
            ro_q      <= '0;
            sectors_q <= '0;
        end else begin
            mounted_q <= mounted_d;
            ro_q      <= ro_d;
            sectors_q <= sectors_d;
        end
    end

    // Out-of-range drive numbers read back as unmounted.
    always_comb begin
        rd_mounted = 1'b0;
        rd_ro      = 1'b0;
        rd_sectors = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (rd_drv == DRV_W'(i)) begin
                rd_mounted = mounted_q[i];
                rd_ro      = ro_q[i];
                rd_sectors = sectors_q[i];
            end
        end
    end

    assign mounted = mounted_q;

endmodule

// File: rtl/sd_drive_arbiter.sv
// Routes single-channel floppy sector requests to one of NUM_DRIVES HPS virtual-disk channels.
// Latency: check error or sd_rd/sd_wr 2 cycles after strobe; done 1 cycle after sd_ack falls.
// Backpressure: strobes are dropped while req_busy; each accepted request ends in one done or err pulse.
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter  int NUM_DRIVES = 2,
    parameter  int LBA_W      = 32,
    parameter  int TIMEOUT    = 1 << 24,
    localparam int DRV_W      = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1,
    localparam int CNT_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [DRV_W-1:0]            drv_sel,
    input  logic                        req_rd,
    input  logic                        req_wr,
    input  logic [LBA_W-1:0]            req_lba,
    output logic                        req_busy,
    output logic                        req_done,
    output logic                        req_err,
    output logic [2:0]                  req_err_code,
    output logic                        core_ack,
    input  logic [7:0]                  core_buff_din,
    input  logic [NUM_DRIVES-1:0]       img_mounted,
    input  logic                        img_readonly,
    input  logic [63:0]                 img_size,
    output logic [NUM_DRIVES-1:0]       mounted,
    output logic [NUM_DRIVES*LBA_W-1:0] sd_lba,
    output logic [NUM_DRIVES-1:0]       sd_rd,
    output logic [NUM_DRIVES-1:0]       sd_wr,
    input  logic [NUM_DRIVES-1:0]       sd_ack,
    output logic [NUM_DRIVES*8-1:0]     sd_buff_din
);

    state_t           state_q, state_d;
    logic [DRV_W-1:0] drv_q, drv_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             eject_q, eject_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;

    logic             rd_mounted, rd_ro;
    logic [LBA_W-1:0] rd_sectors;
    logic             act_ack, act_eject, active;

    sd_drive_table #(
        .NUM_DRIVES (NUM_DRIVES),
        .LBA_W      (LBA_W),
        .DRV_W      (DRV_W)
    ) u_table (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .rd_drv       (drv_q),
        .mounted      (mounted),
        .rd_mounted   (rd_mounted),
        .rd_ro        (rd_ro),
        .rd_sectors   (rd_sectors)
    );

    assign act_ack   = sd_ack[drv_q];
    assign act_eject = img_mounted[drv_q];
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        drv_d      = drv_q;
        lba_d      = lba_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        eject_d    = eject_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    drv_d   = drv_sel;
                    lba_d   = req_lba;
                    wr_d    = !req_rd;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                if (!rd_mounted) begin
                    err_code_d = ERR_NOMOUNT;
                end else if (lba_q >= rd_sectors) begin
                    err_code_d = ERR_RANGE;
                end else if (wr_q && rd_ro) begin
                    err_code_d = ERR_WPROT;
                end else begin
                    err_d   = 1'b0;
                    state_d = ST_REQ;
                    cnt_d   = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // A remount of the target invalidates the request outright.
                if (act_eject) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_EJECT;
                end else if (act_ack) begin
                    state_d = ST_XFER;
                    eject_d = 1'b0;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ST_XFER: begin
                if (act_eject) begin
                    eject_d = 1'b1;
                end
                if (!act_ack) begin
                    state_d = ST_IDLE;
                    if (eject_q || act_eject) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_EJECT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            drv_q      <= '0;
            lba_q      <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            eject_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            drv_q      <= drv_d;
            lba_q      <= lba_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            eject_q    <= eject_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign active       = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign req_busy     = (state_q != ST_IDLE);
    assign req_done     = done_q;
    assign req_err      = err_q;
    assign req_err_code = err_code_q;
    assign core_ack     = active && act_ack;
    assign sd_lba       = {NUM_DRIVES{lba_q}};

    // Request lines decode straight from state so an async reset drops them at once.
    always_comb begin
        sd_rd       = '0;
        sd_wr       = '0;
        sd_buff_din = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (drv_q == DRV_W'(i)) begin
                sd_rd[i] = (state_q == ST_REQ) && !wr_q;
                sd_wr[i] = (state_q == ST_REQ) && wr_q;
                if (active) begin
                    sd_buff_din[i*8 +: 8] = core_buff_din;
                end
            end
        end
    end

endmodule

// File: doc/sd_drive_arbiter.md
# sd_drive_arbiter

Routes the single-channel sector requests of the core's floppy controller to one of `NUM_DRIVES` HPS virtual-disk channels. It sits between the machine core and `hps_io`, and replaces the shared-LBA / OR'd-ack wiring with per-drive routing. Per-drive mount state (mounted, read-only, sector count) is tracked from `img_mounted`. Requests are validated before issue, and every request terminates in exactly one done or error pulse, including on timeout or eject.

## Interface
Parameters:
- `NUM_DRIVES`, 2: number of HPS virtual-disk channels (1..4)
- `LBA_W`, 32: LBA width
- `TIMEOUT`, 2^24: clk_sys cycles allowed in REQ before abort

Ports:
- `clk_sys`  in  1: system clock
- `reset_n`  in  1: asynchronous, active-low reset
- `drv_sel`  in  $clog2(NUM_DRIVES): target drive, sampled on accept
- `req_rd`, `req_wr`  in  1: single-cycle request strobes from the core
- `req_lba`  in  LBA_W: sector address, sampled on accept
- `req_busy`  out  1: transaction in progress
- `req_done`  out  1: one-cycle success pulse
- `req_err`  out  1: one-cycle failure pulse
- `req_err_code`  out  3: valid with `req_err`. 1 NOMOUNT, 2 RANGE, 3 WPROT, 4 TIMEOUT, 5 EJECT
- `core_ack`  out  1: mirrors `sd_ack` of the active drive
- `core_buff_din`  in  8: write data from the core buffer
- `img_mounted`  in  NUM_DRIVES: mount-change pulses
- `img_readonly`  in  1: read-only flag, valid with `img_mounted`
- `img_size`  in  64: image size in bytes, valid with `img_mounted`
- `mounted`  out  NUM_DRIVES: per-drive mounted flags
- `sd_lba`  out  NUM_DRIVES×LBA_W: per-drive LBA
- `sd_rd`, `sd_wr`  out  NUM_DRIVES: per-drive request
- `sd_ack`  in  NUM_DRIVES: per-drive acknowledge
- `sd_buff_din`  out  NUM_DRIVES×8: per-drive write data

## Operation
Drive table:
- On `img_mounted[i]`, load three fields for drive i: `mounted[i]` = |img_size, `ro[i]` = img_readonly, `sectors[i]` = img_size[LBA_W+8:9].
- All three fields update together, in the cycle after the pulse.

State machine, with states IDLE, CHECK, REQ, XFER:
- **IDLE**: on `req_rd|req_wr`, latch `drv_sel`, `req_lba`, and the direction, then go to CHECK. If both strobes are set, read wins. Strobes arriving while busy are ignored.
- **CHECK**: the first failing test, in order, produces `req_err`, its code, and a return to IDLE:
  - drive not mounted → NOMOUNT
  - lba ≥ `sectors[d]` → RANGE
  - write to a read-only drive → WPROT
  - otherwise go to REQ.
- **REQ**: hold `sd_rd[d]` or `sd_wr[d]` high.
  - On `sd_ack[d]` rising, drop the request and go to XFER.
  - If the timeout counter reaches `TIMEOUT`, abort: req_err with TIMEOUT.
  - If `img_mounted[d]` pulses, abort: req_err with EJECT.
- **XFER**: on `sd_ack[d]` falling, return to IDLE and pulse `req_done`. If `img_mounted[d]` pulsed during XFER, pulse `req_err` with EJECT instead of `req_done`.

Routing:
- `sd_lba[i]` = latched lba for every i.
- `sd_buff_din[d]` = `core_buff_din`; all other drives get 0.
- `core_ack` = `sd_ack[d]` while in REQ or XFER, else 0.
- `sd_ack` on inactive drives is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; `mounted` = 0; drive table cleared. Reset asserted mid-transaction drops `sd_rd`/`sd_wr` asynchronously, and no done or error pulse is emitted.
- `req_busy` rises the cycle after accept and falls in the same cycle as the done or error pulse.
- A CHECK failure pulses the error 2 cycles after the strobe.
- `sd_rd`/`sd_wr` rise 2 cycles after the strobe and fall 1 cycle after `sd_ack` rises.
- `req_done` comes 1 cycle after `sd_ack` falls.
- The timeout counter is LBA-independent. It clears on REQ entry and compares with `==`, with no wrap.
- `img_mounted` on a non-active drive never disturbs the current transaction.
- A new strobe is accepted the cycle after the done or error pulse.

## Structure
- Package `sd_arb_pkg`:
  - state enum
  - error-code constants
  - `SECT_SHIFT` = 9
- Sub-module `sd_drive_table`: per-drive mounted/ro/sectors registers, with a read port indexed by the latched drive. The FSM, timeout counter, and routing live in `sd_drive_arbiter`.

## Test plan
- Mount drive 1 (size 0x16800, rw). Read drv 1, lba 5 → `sd_rd[1]` high 2 cycles after the strobe, `sd_lba` = 5. Ack 4 cycles → `core_ack` mirrors it, one `req_done`, `sd_rd[0]` stays 0.
- Read drive 0 while unmounted → `req_err` with code 1, 2 cycles after the strobe. No `sd_rd` activity.
- Mount drive 0 with 0x16800 bytes, read lba 180 → code 2. Read lba 179 → succeeds.
- Mount read-only, write → code 3. `req_rd` and `req_wr` in the same cycle → read issued.
- Set `TIMEOUT` = 16 and never ack → `req_err` code 4 exactly 16 cycles after REQ entry, `sd_rd` low afterward. Remount drive 0 during XFER → `req_err` code 5 on ack fall. Remount drive 1 during a drive-0 read → normal done.
- Deassert `reset_n` in REQ → `sd_rd` drops immediately. After release, `mounted` = 0 and a new request is accepted normally.
